opacc_pipe: RTL and testbench
=============================

OPACC_PIPE -- requirements
Module: opacc_pipe

Interface
REQ-001 SHALL have parameter NREGS, default 2: number of accumulator tiles.
REQ-002 SHALL have parameter XLEN, default 8: element width of ai/bj.
REQ-003 SHALL have parameter VL, default 4: columns per tile (bj lanes).
REQ-004 SHALL have parameter ML, default 4: rows per tile (ai lanes).
REQ-005 SHALL have parameter ACCW, default 32: accumulator element width, ACCW >= 2*XLEN.
REQ-006 SHALL have port clk  input  1: the single clock.
REQ-007 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-008 SHALL have ports ab_valid in 1, ab_ready out 1, ab_addr in $clog2(NREGS), ab_signed in 1, ai in ML*XLEN, bj in VL*XLEN: outer-product beat.
REQ-009 SHALL have ports ci_valid in 1, ci_ready out 1, cld_addr in $clog2(NREGS), ci in VL*ACCW: C-row load beat.
REQ-010 SHALL have ports cst_req in 1, cst_addr in $clog2(NREGS), co_valid out 1, co_ready in 1, co out VL*ACCW, co_row out $clog2(ML): C-row store stream.
REQ-011 SHALL have port busy  output  1: high when state != IDLE or the MAC pipeline is non-empty.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, STORE; reset state IDLE.
REQ-013 IDLE priority, evaluated only when MAC pipeline empty: cst_req -> STORE; else ci_valid -> LOAD, with that cycle's ci taken as row 0.
REQ-014 ab_ready SHALL equal (state==IDLE) && !cst_req && !ci_valid; ab beats are accepted on ab_valid && ab_ready.
REQ-015 ci_ready SHALL be high in LOAD, and in IDLE when pipeline empty and !cst_req; low otherwise.
REQ-016 LOAD: accepted beat k (k=0..ML-1) SHALL write ci into row k of tile cld_addr (address latched at first beat); after the row ML-1 beat -> IDLE. Gaps in ci_valid SHALL stall without advancing the row count.
REQ-017 STORE: SHALL present row r of tile cst_addr (latched) on co with co_row=r, co_valid=1, r=0..ML-1; r advances only on co_valid && co_ready; after row ML-1 is taken -> IDLE.
REQ-018 MAC pipeline, 2 stages: stage 1 SHALL register the ML*VL products ai[i]*bj[j] (signed if ab_signed, else unsigned, 2*XLEN bits) with ab_addr; stage 2 SHALL add each product, sign- or zero-extended to ACCW, into tile[ab_addr][i][j].
REQ-019 An accepted ab beat SHALL be visible in the tile 2 cycles later; back-to-back beats to the same tile SHALL accumulate correctly (one beat per cycle sustained).
REQ-020 Without saturation, accumulation SHALL wrap modulo 2^ACCW.
REQ-021 Tiles not addressed by an active write SHALL hold value.
REQ-022 co SHALL be 0 and co_row 0 whenever co_valid is low.

Reset
REQ-023 reset SHALL force: state IDLE, pipeline flushed (in-flight products discarded), all tile elements 0, ab_ready/ci_ready per REQ-014/015 with empty pipeline, co_valid 0, co 0, co_row 0, busy 0.
REQ-024 reset asserted mid-LOAD or mid-STORE SHALL abort the transfer; partially loaded rows are cleared to 0.

Configuration
REQ-025 Macro OPACC_SAT_EN defined SHALL make stage-2 accumulation saturating: signed range [-2^(ACCW-1), 2^(ACCW-1)-1] when the beat's ab_signed=1, else [0, 2^ACCW-1].
REQ-026 Macro OPACC_SAT_EN undefined SHALL give wrapping accumulation per REQ-020, with no saturation logic present.

Verification
REQ-027 Load tile 1 rows k=0..3 with ci[j]=k*j, store tile 1 with co_ready=1 -> co_row 0..3 on consecutive cycles, co[j]=row*j.
REQ-028 Tile 0 zero, 4 back-to-back ab beats k=0..3, ai[i]=i*k, bj[j]=j*k, unsigned -> 2 cycles after last beat tile0[i][j]=14*i*j.
REQ-029 ab_signed=1, ai all 0xFF, bj all 0x02, one beat into zeroed tile -> every element equals -2 (0xFFFFFFFE).
REQ-030 ci_valid and cst_req both high in IDLE with pipeline busy -> neither accepted until 2 cycles after last ab beat, then STORE entered; co_ready toggling 1,0,1 stalls co_row at its value while low.
REQ-031 Preload element 0x7FFFFFFF, signed beat adding +1 -> 0x7FFFFFFF with OPACC_SAT_EN, 0x80000000 without.
REQ-032 reset pulsed during STORE row 2 -> next cycle co_valid=0, state IDLE, subsequent store of any tile returns all zeros.

Source files
------------

// File: rtl/opacc_pipe.sv
// Outer-product accumulator: NREGS tiles of ML x VL elements, a 2-stage MAC pipeline,
// and row-wise C load/store streams. Define OPACC_SAT_EN for saturating accumulation.
module opacc_pipe #(
  parameter int NREGS = 2,
  parameter int XLEN  = 8,
  parameter int VL    = 4,
  parameter int ML    = 4,
  parameter int ACCW  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ab_valid,
  output logic                       ab_ready,
  input  logic [$clog2(NREGS)-1:0]   ab_addr,
  input  logic                       ab_signed,
  input  logic [ML*XLEN-1:0]         ai,
  input  logic [VL*XLEN-1:0]         bj,
  input  logic                       ci_valid,
  output logic                       ci_ready,
  input  logic [$clog2(NREGS)-1:0]   cld_addr,
  input  logic [VL*ACCW-1:0]         ci,
  input  logic                       cst_req,
  input  logic [$clog2(NREGS)-1:0]   cst_addr,
  output logic                       co_valid,
  input  logic                       co_ready,
  output logic [VL*ACCW-1:0]         co,
  output logic [$clog2(ML)-1:0]      co_row,
  output logic                       busy
);
  localparam int AW = $clog2(NREGS);
  localparam int RW = $clog2(ML);
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  function automatic logic [PW-1:0] mul_elem(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic sgn);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    if (sgn) begin
      sa = PW'($signed(a));
      sb = PW'($signed(b));
    end else begin
      sa = $signed(PW'(a));
      sb = $signed(PW'(b));
    end
    return sa * sb;
  endfunction

  function automatic logic [ACCW-1:0] ext_prod(input logic [PW-1:0] p, input logic sgn);
    logic signed [PW-1:0] ps;
    logic [ACCW-1:0]      e;
    ps = $signed(p);
    if (sgn) e = ACCW'(ps);
    else     e = ACCW'(p);
    return e;
  endfunction

  function automatic logic [ACCW-1:0] acc_add(input logic [ACCW-1:0] acc, input logic [PW-1:0] p,
                                              input logic sgn);
`ifdef OPACC_SAT_EN
    logic [ACCW-1:0] e;
    logic [ACCW:0]   sum;
    e = ext_prod(p, sgn);
    if (sgn) begin
      sum = {acc[ACCW-1], acc} + {e[ACCW-1], e};
      if (sum[ACCW] != sum[ACCW-1])
        return sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end else begin
      sum = {1'b0, acc} + {1'b0, e};
      if (sum[ACCW]) return '1;
    end
    return sum[ACCW-1:0];
`else
    return acc + ext_prod(p, sgn);
`endif
  endfunction

  state_t          state_q;
  logic [RW-1:0]   row_q;
  logic [AW-1:0]   xaddr_q;
  logic [ACCW-1:0] tile_q [NREGS][ML][VL];

  logic            vld_p1;
  logic [AW-1:0]   addr_p1;
  logic            sgn_p1;
  logic [PW-1:0]   prod_p1 [ML][VL];

  logic            ab_fire, ci_fire, pipe_empty;
  logic [AW-1:0]   ld_addr;
  logic [RW-1:0]   ld_row;

  assign pipe_empty = !vld_p1;
  assign ab_ready   = (state_q == IDLE) && !cst_req && !ci_valid;
  assign ci_ready   = (state_q == LOAD) || ((state_q == IDLE) && pipe_empty && !cst_req);
  assign ab_fire    = ab_valid && ab_ready;
  assign ci_fire    = ci_valid && ci_ready;
  assign busy       = (state_q != IDLE) || vld_p1;
  // The first load beat arrives in IDLE, before the address and row count are latched.
  assign ld_addr    = (state_q == IDLE) ? cld_addr : xaddr_q;
  assign ld_row     = (state_q == IDLE) ? '0 : row_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      xaddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pipe_empty) begin
            if (cst_req) begin
              state_q <= STORE;
              xaddr_q <= cst_addr;
              row_q   <= '0;
            end else if (ci_valid) begin
              state_q <= LOAD;
              xaddr_q <= cld_addr;
              row_q   <= RW'(1);
            end
          end
        end
        LOAD: begin
          if (ci_valid) begin
            if (row_q == RW'(ML - 1)) begin
              state_q <= IDLE;
              row_q   <= '0;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        STORE: begin
          if (co_ready) begin
            if (row_q == RW'(ML - 1)) begin
              state_q <= IDLE;
              row_q   <= '0;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage 1: products
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= ab_fire;
  end

  always_ff @(posedge clk) begin
    if (ab_fire) begin
      addr_p1 <= ab_addr;
      sgn_p1  <= ab_signed;
      for (int i = 0; i < ML; i++)
        for (int j = 0; j < VL; j++)
          prod_p1[i][j] <= mul_elem(ai[i*XLEN +: XLEN], bj[j*XLEN +: XLEN], ab_signed);
    end
  end

  // Stage 2: accumulate into tile; loads never overlap an in-flight MAC
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NREGS; t++)
        for (int i = 0; i < ML; i++)
          for (int j = 0; j < VL; j++)
            tile_q[t][i][j] <= '0;
    end else begin
      if (vld_p1) begin
        for (int i = 0; i < ML; i++)
          for (int j = 0; j < VL; j++)
            tile_q[addr_p1][i][j] <= acc_add(tile_q[addr_p1][i][j], prod_p1[i][j], sgn_p1);
      end
      if (ci_fire) begin
        for (int j = 0; j < VL; j++)
          tile_q[ld_addr][ld_row][j] <= ci[j*ACCW +: ACCW];
      end
    end
  end

  assign co_valid = (state_q == STORE);

  always_comb begin
    co     = '0;
    co_row = '0;
    if (co_valid) begin
      co_row = row_q;
      for (int j = 0; j < VL; j++)
        co[j*ACCW +: ACCW] = tile_q[xaddr_q][row_q][j];
    end
  end

endmodule

// File: tb/tb_opacc_pipe.sv
// Randomized and directed bench for opacc_pipe against a tile-level reference model.
// Honors OPACC_SAT_EN for the expected accumulation behaviour.
module tb_opacc_pipe;
  localparam int NREGS = 2;
  localparam int XLEN  = 8;
  localparam int VL    = 4;
  localparam int ML    = 4;
  localparam int ACCW  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              ab_valid, ab_ready, ab_signed;
  logic [0:0]        ab_addr, cld_addr, cst_addr;
  logic [31:0]       ai, bj;
  logic              ci_valid, ci_ready;
  logic [127:0]      ci;
  logic              cst_req, co_valid, co_ready;
  logic [127:0]      co;
  logic [1:0]        co_row;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [31:0]  m_tile [NREGS][ML][VL];
  bit           m_ld_active, m_st_active, chk_en;
  int           m_ld_addr, m_ld_row, m_st_addr, m_st_row, st_req_addr;
  logic [127:0] cap [ML];
  logic [127:0] ld_data [ML];
  int           nvalid;

  opacc_pipe #(.NREGS(NREGS), .XLEN(XLEN), .VL(VL), .ML(ML), .ACCW(ACCW)) dut (
    .clk(clk), .reset(reset),
    .ab_valid(ab_valid), .ab_ready(ab_ready), .ab_addr(ab_addr), .ab_signed(ab_signed),
    .ai(ai), .bj(bj),
    .ci_valid(ci_valid), .ci_ready(ci_ready), .cld_addr(cld_addr), .ci(ci),
    .cst_req(cst_req), .cst_addr(cst_addr), .co_valid(co_valid), .co_ready(co_ready),
    .co(co), .co_row(co_row), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] acc_model(input logic [31:0] m, input longint p, input bit s);
    longint sum;
`ifdef OPACC_SAT_EN
    if (s) begin
      sum = longint'($signed(m)) + p;
      if (sum > 64'sd2147483647) sum = 64'sd2147483647;
      if (sum < -(64'sd2147483648)) sum = -(64'sd2147483648);
    end else begin
      sum = longint'({32'b0, m}) + p;
      if (sum > 64'sd4294967295) sum = 64'sd4294967295;
    end
`else
    sum = longint'({32'b0, m}) + p;
`endif
    return sum[31:0];
  endfunction

  // Compare DUT outputs to the model, then fold this cycle's accepted transfers into it.
  always @(negedge clk) begin
    logic [127:0] exp_co;
    logic [7:0]   a8, b8;
    longint       p;
    if (chk_en) begin
      if (co_valid) begin
        if (!m_st_active) begin
          m_st_active = 1'b1;
          m_st_addr   = st_req_addr;
          m_st_row    = 0;
        end
        for (int j = 0; j < VL; j++) exp_co[j*32 +: 32] = m_tile[m_st_addr][m_st_row][j];
        chk("co_row", 128'(co_row), 128'(m_st_row));
        chk("co_data", co, exp_co);
        chk("busy_store", 128'(busy), 128'(1));
        if (co_ready) begin
          m_st_row++;
          if (m_st_row == ML) m_st_active = 1'b0;
        end
      end else begin
        chk("co_idle_data", co, 128'(0));
        chk("co_idle_row", 128'(co_row), 128'(0));
        chk("store_early_end", 128'(m_st_active), 128'(0));
      end
    end
    if (reset) begin
      for (int t = 0; t < NREGS; t++)
        for (int i = 0; i < ML; i++)
          for (int j = 0; j < VL; j++) m_tile[t][i][j] = '0;
      m_ld_active = 1'b0;
      m_st_active = 1'b0;
    end else begin
      if (ab_valid && ab_ready) begin
        for (int i = 0; i < ML; i++)
          for (int j = 0; j < VL; j++) begin
            a8 = ai[i*8 +: 8];
            b8 = bj[j*8 +: 8];
            if (ab_signed) p = longint'($signed(a8)) * longint'($signed(b8));
            else           p = longint'(a8) * longint'(b8);
            m_tile[ab_addr][i][j] = acc_model(m_tile[ab_addr][i][j], p, ab_signed);
          end
      end
      if (ci_valid && ci_ready) begin
        if (!m_ld_active) begin
          m_ld_active = 1'b1;
          m_ld_addr   = int'(cld_addr);
          m_ld_row    = 0;
        end
        for (int j = 0; j < VL; j++) m_tile[m_ld_addr][m_ld_row][j] = ci[j*32 +: 32];
        m_ld_row++;
        if (m_ld_row == ML) m_ld_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ab_valid = 1'b0; ci_valid = 1'b0; cst_req = 1'b0; co_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic ab_beat(input int a, input bit sgn, input logic [31:0] av, input logic [31:0] bv);
    bit acc;
    ab_addr = 1'(a); ab_signed = sgn; ai = av; bj = bv; ab_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk) acc = ab_ready;
      tick();
    end
    if (!acc) chk("ab_accept_timeout", 128'(0), 128'(1));
    ab_valid = 1'b0;
  endtask

  task automatic load_tile(input int a, input bit gaps);
    bit acc;
    cld_addr = 1'(a);
    for (int k = 0; k < ML; k++) begin
      ci = ld_data[k];
      ci_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 100 && !acc; c++) begin
        @(negedge clk) acc = ci_ready;
        tick();
      end
      if (!acc) chk("ci_accept_timeout", 128'(0), 128'(1));
      if (gaps) begin
        cld_addr = 1'(a ^ 1);
        if ($urandom_range(1, 0) == 1) begin
          ci_valid = 1'b0;
          tick();
        end
      end
    end
    ci_valid = 1'b0;
  endtask

  task automatic store_capture(input int a, input bit rnd_ready);
    bit done;
    st_req_addr = a;
    cst_addr = 1'(a);
    cst_req = 1'b1;
    co_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    done = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (co_valid) begin
        nvalid++;
        if (co_ready) begin
          cap[co_row] = co;
          if (co_row == 2'(ML - 1)) done = 1'b1;
        end
      end
      tick();
      if (nvalid > 0) cst_req = 1'b0;
      co_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
    if (!done) chk("store_timeout", 128'(0), 128'(1));
    cst_req = 1'b0;
    co_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] av, bv;
    logic [31:0] exp32;
    bit acc;
    reset = 1'b1; ab_valid = 1'b0; ab_addr = '0; ab_signed = 1'b0; ai = '0; bj = '0;
    ci_valid = 1'b0; cld_addr = '0; ci = '0; cst_req = 1'b0; cst_addr = '0; co_ready = 1'b1;
    chk_en = 1'b0; st_req_addr = 0;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state and ready decoding
    chk("rst_co_valid", 128'(co_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ab_ready", 128'(ab_ready), 128'(1));
    chk("rst_ci_ready", 128'(ci_ready), 128'(1));
    chk("rst_co", co, 128'(0));
    cst_req = 1'b1;
    #1;
    chk("ab_ready_cst", 128'(ab_ready), 128'(0));
    chk("ci_ready_cst", 128'(ci_ready), 128'(0));
    cst_req = 1'b0;
    ci_valid = 1'b1;
    #1;
    chk("ab_ready_ci", 128'(ab_ready), 128'(0));
    ci_valid = 1'b0;
    tick();

    // Tile 1 load k*j then store
    for (int k = 0; k < ML; k++)
      for (int j = 0; j < VL; j++) ld_data[k][j*32 +: 32] = 32'(k * j);
    load_tile(1, 1'b0);
    store_capture(1, 1'b0);
    chk("store_consecutive", 128'(nvalid), 128'(ML));
    for (int r = 0; r < ML; r++)
      for (int j = 0; j < VL; j++) chk("load_store_lit", 128'(cap[r][j*32 +: 32]), 128'(r * j));

    // Four back-to-back unsigned beats into tile 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        av[i*8 +: 8] = 8'(i * k);
        bv[i*8 +: 8] = 8'(i * k);
      end
      ab_beat(0, 1'b0, av, bv);
    end
    store_capture(0, 1'b0);
    for (int i = 0; i < ML; i++)
      for (int j = 0; j < VL; j++) chk("mac_b2b_lit", 128'(cap[i][j*32 +: 32]), 128'(14 * i * j));

    // Signed -1 * 2
    do_reset();
    ab_beat(0, 1'b1, 32'hFFFFFFFF, 32'h02020202);
    store_capture(0, 1'b0);
    for (int i = 0; i < ML; i++)
      for (int j = 0; j < VL; j++) chk("signed_lit", 128'(cap[i][j*32 +: 32]), 128'(32'hFFFFFFFE));

    // Load and store both requested while the pipeline drains
    do_reset();
    ab_beat(0, 1'b0, 32'h04030201, 32'h01020304);
    ab_beat(0, 1'b1, 32'h80FF7F01, 32'hFF017F80);
    st_req_addr = 0; cst_addr = 1'b0; cst_req = 1'b1;
    ci_valid = 1'b1; cld_addr = 1'b1; ci = {4{32'h12345678}}; co_ready = 1'b1;
    @(negedge clk);
    chk("arb_busy_ci_ready", 128'(ci_ready), 128'(0));
    chk("arb_busy_co_valid", 128'(co_valid), 128'(0));
    chk("arb_busy_ab_ready", 128'(ab_ready), 128'(0));
    tick();
    @(negedge clk);
    chk("arb_drain_co_valid", 128'(co_valid), 128'(0));
    chk("arb_drain_ci_ready", 128'(ci_ready), 128'(0));
    tick();
    cst_req = 1'b0; ci_valid = 1'b0;
    @(negedge clk);
    chk("arb_store_entered", 128'(co_valid), 128'(1));
    chk("arb_row0", 128'(co_row), 128'(0));
    tick();
    co_ready = 1'b0;
    @(negedge clk);
    chk("stall_row1", 128'(co_row), 128'(1));
    tick();
    co_ready = 1'b1;
    @(negedge clk);
    chk("stall_hold_row1", 128'(co_row), 128'(1));
    tick();
    @(negedge clk);
    chk("stall_row2", 128'(co_row), 128'(2));
    repeat (3) tick();
    chk("arb_store_done", 128'(co_valid), 128'(0));

    // Overflow at the top of the signed range
    do_reset();
    for (int k = 0; k < ML; k++) ld_data[k] = '0;
    ld_data[0][31:0] = 32'h7FFFFFFF;
    load_tile(1, 1'b0);
    ab_beat(1, 1'b1, 32'h00000001, 32'h00000001);
    store_capture(1, 1'b0);
`ifdef OPACC_SAT_EN
    exp32 = 32'h7FFFFFFF;
`else
    exp32 = 32'h80000000;
`endif
    chk("overflow_lit", 128'(cap[0][31:0]), 128'(exp32));

    // Reset in the middle of a store
    for (int k = 0; k < ML; k++) ld_data[k] = {32'(k + 9), 32'(k + 5), 32'(k + 3), 32'(k + 1)};
    load_tile(1, 1'b1);
    st_req_addr = 1; cst_addr = 1'b1; cst_req = 1'b1; co_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk) acc = co_valid && (co_row == 2'd1);
      tick();
      if (co_valid) cst_req = 1'b0;
    end
    if (!acc) chk("midstore_timeout", 128'(0), 128'(1));
    chk("midstore_row2", 128'(co_row), 128'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_co_valid", 128'(co_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_co", co, 128'(0));
    for (int t = 0; t < NREGS; t++) begin
      store_capture(t, 1'b0);
      for (int r = 0; r < ML; r++) chk("abort_zero", cap[r], 128'(0));
    end

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(9, 0));
      if (r < 6) begin
        ab_beat(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom, $urandom);
      end else if (r < 8) begin
        for (int k = 0; k < ML; k++) ld_data[k] = {$urandom, $urandom, $urandom, $urandom};
        load_tile(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end else begin
        store_capture(int'($urandom_range(1, 0)), 1'b1);
      end
    end
    store_capture(0, 1'b1);
    store_capture(1, 1'b0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
